// File: rtl/invcb_pipe.sv
// invcb_pipe: 5-stage inverse skin-tone Cb transform with valid/ready stall.
// Optional saturation event counter built only when INVCB_SAT_CNT_EN is defined.
module invcb_pipe #(
  parameter int TRANS_W   = 16,
  parameter int FRAC_W    = 6,
  parameter int K_L       = 125,
  parameter int K_H       = 188,
  parameter int MEAN_KH   = 6912,
  parameter int RECIP_WCB = 1395
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                Y,
  input  logic signed [TRANS_W-1:0] transcb,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [7:0]                Cb,
  output logic [15:0]               sat_count
);
  localparam int LUT_W     = FRAC_W + 8;
  localparam int D_W       = TRANS_W + 1;
  localparam int P_W       = D_W + LUT_W + 1;
  localparam int Q_W       = P_W + 13;
  localparam int Y_MIN     = 16;
  localparam int Y_MAX     = 235;
  localparam int MEAN_SPAN = 10 << FRAC_W;
  localparam int WL_BASE   = 23 << FRAC_W;
  localparam int WH_BASE   = 14 << FRAC_W;
  localparam int WL_SLOPE  = ((2397 << FRAC_W) + 50) / 100;
  localparam int WH_SLOPE  = ((3297 << FRAC_W) + 50) / 100;
  localparam int W_CB_Q    = ((4697 << FRAC_W) + 50) / 100;
  localparam logic [7:0] KL8 = 8'(K_L);
  localparam logic [7:0] KH8 = 8'(K_H);
  // Luma outside the nominal video range reuses the end-point LUT entries.
  function automatic int clamp_y(input logic [7:0] y);
    return (int'(y) < Y_MIN) ? Y_MIN : (int'(y) > Y_MAX) ? Y_MAX : int'(y);
  endfunction
  function automatic logic [LUT_W-1:0] mean_lut(input logic [7:0] y);
    int yc;
    yc = clamp_y(y);
    return LUT_W'(yc < K_L ? MEAN_KH + ((K_L - yc) * MEAN_SPAN + (K_L - Y_MIN) / 2) / (K_L - Y_MIN)
                : yc > K_H ? MEAN_KH + ((yc - K_H) * MEAN_SPAN + (Y_MAX - K_H) / 2) / (Y_MAX - K_H)
                : MEAN_KH);
  endfunction
  function automatic logic [LUT_W-1:0] width_lut(input logic [7:0] y);
    int yc;
    yc = clamp_y(y);
    return LUT_W'(yc < K_L ? WL_BASE + ((yc - Y_MIN) * WL_SLOPE + (K_L - Y_MIN) / 2) / (K_L - Y_MIN)
                : yc > K_H ? WH_BASE + ((Y_MAX - yc) * WH_SLOPE + (Y_MAX - K_H) / 2) / (Y_MAX - K_H)
                : W_CB_Q);
  endfunction
  logic                      en;
  logic                      v0, v1, v2, v3;
  logic [7:0]                y0;
  logic signed [TRANS_W-1:0] t0, t1, t2;
  logic                      byp0, byp1, byp2;
  logic signed [D_W-1:0]     d1;
  logic [LUT_W-1:0]          w1, m1, m2;
  logic signed [P_W-1:0]     prod2, p2;
  logic signed [Q_W-1:0]     prod3, q3_n, q3, rr;
  logic                      lo, hi;
  logic [7:0]                cb_n;
  assign en       = ~(out_valid & ~out_ready);
  assign in_ready = en;
  assign byp0     = (y0 >= KL8) && (y0 <= KH8);
  assign prod2    = P_W'(d1) * P_W'($signed({1'b0, w1}));
  assign prod3    = Q_W'(p2) * Q_W'(RECIP_WCB);
  assign q3_n     = byp2 ? Q_W'(t2) : (prod3 >>> 16) + Q_W'($signed({1'b0, m2}));
  assign rr       = (q3 + Q_W'(2 ** (FRAC_W - 1))) >>> FRAC_W;
  assign lo       = rr[Q_W-1];
  assign hi       = !rr[Q_W-1] && |rr[Q_W-2:8];
  assign cb_n     = lo ? 8'd0 : hi ? 8'd255 : rr[7:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0 <= 1'b0; v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; out_valid <= 1'b0;
      y0 <= '0; t0 <= '0; t1 <= '0; t2 <= '0;
      byp1 <= 1'b0; byp2 <= 1'b0;
      d1 <= '0; w1 <= '0; m1 <= '0; m2 <= '0;
      p2 <= '0; q3 <= '0; Cb <= '0;
    end else if (en) begin
      v0 <= in_valid;
      y0 <= Y;
      t0 <= transcb;
      v1 <= v0;
      byp1 <= byp0;
      t1 <= t0;
      d1 <= D_W'(t0) - D_W'(MEAN_KH);
      w1 <= width_lut(y0);
      m1 <= mean_lut(y0);
      v2 <= v1;
      byp2 <= byp1;
      t2 <= t1;
      p2 <= prod2 >>> FRAC_W;
      m2 <= m1;
      v3 <= v2;
      q3 <= q3_n;
      out_valid <= v3;
      Cb <= cb_n;
    end
  end
`ifdef INVCB_SAT_CNT_EN
  logic sat4;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat4 <= 1'b0;
      sat_count <= '0;
    end else begin
      if (en) sat4 <= lo | hi;
      if (out_valid && out_ready && sat4 && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
    end
  end
`else
  assign sat_count = '0;
`endif
endmodule

// File: tb/tb_invcb_pipe.sv
// tb_invcb_pipe: scoreboard bench for invcb_pipe (bypass, round trip, saturation, stall, reset).
module tb_invcb_pipe;
`ifdef INVCB_SAT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif
  typedef struct { int cb; int tol; } exp_t;
  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [7:0]         Y = '0;
  logic signed [15:0] transcb = '0;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [7:0]         Cb;
  logic [15:0]        sat_count;
  exp_t               sb[$];
  int                 tests = 0;
  int                 fails = 0;
  invcb_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .Y(Y),
    .transcb(transcb), .out_valid(out_valid), .out_ready(out_ready), .Cb(Cb), .sat_count(sat_count)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output Cb=%0d required no output", Cb);
      end else begin
        exp_t e;
        int d;
        e = sb.pop_front();
        d = int'(Cb) - e.cb;
        if (d > e.tol || d < -e.tol) begin
          fails++;
          $display("FAIL out_cb got %0d required %0d (+-%0d)", Cb, e.cb, e.tol);
        end
      end
    end
  end
  function automatic int bypass_exp(input int t);
    int r;
    r = (t + 32) >>> 6;
    return r < 0 ? 0 : r > 255 ? 255 : r;
  endfunction
  function automatic real mean_r(input int y);
    return y < 125 ? 108.0 + (125 - y) * 10.0 / 109.0 : y > 188 ? 108.0 + (y - 188) * 10.0 / 47.0 : 108.0;
  endfunction
  function automatic real width_r(input int y);
    return y < 125 ? 23.0 + (y - 16) * 23.97 / 109.0 : y > 188 ? 14.0 + (235 - y) * 32.97 / 47.0 : 46.97;
  endfunction
  task automatic send(input int y, input int t, input int e, input int tol);
    int n = 0;
    Y = 8'(y);
    transcb = 16'(t);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout in_ready=%0b required 1", in_ready);
    end else sb.push_back('{e, tol});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask
  task automatic send_timed(input int y, input int t, input int e, output int lat);
    send(y, t, e, 0);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!out_valid && lat < 20);
  endtask
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain outstanding=%0d required 0", sb.size());
    end
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    tests += 3;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %0b required 0", out_valid); end
    if (Cb !== 8'd0) begin fails++; $display("FAIL rst_cb got %0d required 0", Cb); end
    if (sat_count !== 16'd0) begin fails++; $display("FAIL rst_sat_count got %0d required 0", sat_count); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready got %0b required 1", in_ready); end
  endtask
  task automatic test_bypass();
    int lat;
    send_timed(150, 6400, 100, lat);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL bypass_latency got %0d required 5", lat); end
    drain();
    tests++;
    if (sat_count !== 16'd0) begin fails++; $display("FAIL bypass_sat_count got %0d required 0", sat_count); end
  endtask
  task automatic test_saturation();
    send(20, -32768, 0, 0);
    drain();
    tests++;
    if (sat_count !== (CNT_ON ? 16'd1 : 16'd0)) begin fails++; $display("FAIL sat_low_count got %0d required %0d", sat_count, CNT_ON ? 1 : 0); end
    send(230, 32767, 255, 0);
    drain();
    tests++;
    if (sat_count !== (CNT_ON ? 16'd2 : 16'd0)) begin fails++; $display("FAIL sat_high_count got %0d required %0d", sat_count, CNT_ON ? 2 : 0); end
  endtask
  task automatic test_round_trip();
    int ys[5] = '{16, 60, 124, 189, 235};
    for (int i = 0; i < 5; i++) begin
      for (int cb = 0; cb < 256; cb++) begin
        real cbp;
        int t;
        cbp = (cb - mean_r(ys[i])) * 46.97 / width_r(ys[i]) + 108.0;
        t = $rtoi($floor(cbp * 64.0 + 0.5));
        if (t <= 32767 && t >= -32768) send(ys[i], t, cb, 1);
      end
    end
    drain();
  endtask
  task automatic test_back_to_back();
    fork
      for (int k = 0; k < 8; k++) begin
        int t;
        t = ((k * 17 + 3) << 6) + k * 9;
        send(150, t, bypass_exp(t), 0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          tests += 2;
          if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got %0b required 0", in_ready); end
          if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_out_valid got %0b required 1", out_valid); end
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
  endtask
  task automatic test_reset_mid_stream();
    int lat;
    for (int k = 0; k < 6; k++) send(150, (k + 10) << 6, k + 10, 0);
    rst_n = 1'b0;
    #1;
    sb.delete();
    tests += 2;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_out_valid got %0b required 0", out_valid); end
    if (sat_count !== 16'd0) begin fails++; $display("FAIL midrst_sat_count got %0d required 0", sat_count); end
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_idle out_valid got %0b required 0", out_valid); end
    send_timed(150, 64, 1, lat);
    tests++;
    if (lat != 5) begin fails++; $display("FAIL midrst_latency got %0d required 5", lat); end
    drain();
  endtask
  task automatic test_counter_ceiling();
    for (int i = 0; i < 65537; i++) send(20, -32768, 0, 0);
    drain();
    tests++;
    if (sat_count !== (CNT_ON ? 16'hFFFF : 16'h0000)) begin fails++; $display("FAIL ceiling_count got %0h required %0h", sat_count, CNT_ON ? 16'hFFFF : 16'h0000); end
  endtask
  initial begin
    test_reset();
    test_bypass();
    test_saturation();
    test_round_trip();
    test_back_to_back();
    test_reset_mid_stream();
    test_counter_ceiling();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
